// File: rtl/nts_rx_dispatcher.sv
// NTS receive dispatcher: captures MAC RX frames into ping-pong word buffers, hands
// complete frames to the engine, and decodes the register API (local counters + engine forwarding).
module nts_rx_dispatcher #(
    parameter int ENGINES        = 1,
    parameter int ADDR_WIDTH     = 7,
    parameter int API_ADDR_WIDTH = 12,
    parameter int API_RW_WIDTH   = 32,
    parameter int MAC_DATA_WIDTH = 64
) (
    input  logic                              i_clk,
    input  logic                              i_areset_n,
    input  logic [MAC_DATA_WIDTH/8-1:0]       i_rx_data_valid,
    input  logic [MAC_DATA_WIDTH-1:0]         i_rx_data,
    input  logic                              i_rx_bad_frame,
    input  logic                              i_rx_good_frame,
    output logic                              o_dispatch_packet_available,
    input  logic                              i_dispatch_packet_read_discard,
    output logic [ADDR_WIDTH-1:0]             o_dispatch_counter,
    output logic [MAC_DATA_WIDTH/8-1:0]       o_dispatch_data_valid,
    output logic                              o_dispatch_fifo_empty,
    input  logic                              i_dispatch_fifo_rd_start,
    output logic                              o_dispatch_fifo_rd_valid,
    output logic [MAC_DATA_WIDTH-1:0]         o_dispatch_fifo_rd_data,
    input  logic                              i_api_cs,
    input  logic                              i_api_we,
    input  logic [API_ADDR_WIDTH-1:0]         i_api_address,
    input  logic [API_RW_WIDTH-1:0]           i_api_write_data,
    output logic [API_RW_WIDTH-1:0]           o_api_read_data,
    output logic [ENGINES-1:0]                o_engine_cs,
    output logic                              o_engine_we,
    output logic [API_ADDR_WIDTH-1:0]         o_engine_address,
    output logic [API_RW_WIDTH-1:0]           o_engine_write_data,
    input  logic [API_RW_WIDTH*ENGINES-1:0]   i_engine_read_data
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int MASK_W = MAC_DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   PTR_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    logic [MAC_DATA_WIDTH-1:0] buf_mem [0:2*DEPTH-1];

    logic                    wr_sel_q, wr_sel_d;
    logic [ADDR_WIDTH:0]     wr_ptr_q, wr_ptr_d;
    logic                    oversize_q, oversize_d;
    logic [MASK_W-1:0]       last_mask_q, last_mask_d;
    logic                    pkt_avail_q, pkt_avail_d;
    logic [ADDR_WIDTH-1:0]   counter_q, counter_d;
    logic [MASK_W-1:0]       dv_q, dv_d;
    logic                    stream_active_q, stream_active_d;
    logic                    stream_done_q, stream_done_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [MAC_DATA_WIDTH-1:0] rd_data_q;
    logic [31:0]             good_cnt_q, good_cnt_d;
    logic [31:0]             bad_cnt_q, bad_cnt_d;
    logic [31:0]             drop_cnt_q, drop_cnt_d;

    logic                    cap_any, cap_write, ovs_eff;
    logic [ADDR_WIDTH:0]     ptr_eff;
    logic [MASK_W-1:0]       mask_eff;
    logic                    fifo_empty;
    logic                    good_inc, bad_inc, drop_inc, cnt_clear;
    logic [1:0]              api_sel;
    logic [9:0]              local_addr;
    logic [API_RW_WIDTH-1:0] api_rdata;
    logic [ENGINES-1:0]      engine_cs;

    // A word arriving alongside good/bad belongs to the ending frame, so the end-of-frame
    // decision uses these "effective" values that already include it.
    assign cap_any   = |i_rx_data_valid;
    assign cap_write = cap_any && !wr_ptr_q[ADDR_WIDTH];
    assign ptr_eff   = wr_ptr_q + (cap_write ? PTR_ONE : '0);
    assign ovs_eff   = oversize_q | (cap_any & wr_ptr_q[ADDR_WIDTH]);
    assign mask_eff  = cap_write ? i_rx_data_valid : last_mask_q;

    assign fifo_empty = !(pkt_avail_q && !stream_done_q);
    assign api_sel    = i_api_address[11:10];
    assign local_addr = i_api_address[9:0];
    assign cnt_clear  = i_api_cs && i_api_we && (api_sel == 2'd0) && (local_addr == 10'h006);

    always_comb begin
        wr_sel_d        = wr_sel_q;
        wr_ptr_d        = wr_ptr_q;
        oversize_d      = oversize_q;
        last_mask_d     = last_mask_q;
        pkt_avail_d     = pkt_avail_q;
        counter_d       = counter_q;
        dv_d            = dv_q;
        stream_active_d = stream_active_q;
        stream_done_d   = stream_done_q;
        rd_addr_d       = rd_addr_q;
        rd_valid_d      = 1'b0;
        good_inc        = 1'b0;
        bad_inc         = 1'b0;
        drop_inc        = 1'b0;

        if (cap_write) begin
            wr_ptr_d    = ptr_eff;
            last_mask_d = i_rx_data_valid;
        end
        if (cap_any && wr_ptr_q[ADDR_WIDTH]) oversize_d = 1'b1;

        if (stream_active_q) begin
            rd_valid_d = 1'b1;
            rd_addr_d  = rd_addr_q + ADDR_ONE;
            if (rd_addr_q == counter_q) begin
                stream_active_d = 1'b0;
                stream_done_d   = 1'b1;
            end
        end
        if (i_dispatch_fifo_rd_start && !fifo_empty && !stream_active_q) begin
            stream_active_d = 1'b1;
            rd_addr_d       = '0;
        end

        // Discard is applied before the end-of-frame decision so a coinciding good frame fits.
        if (i_dispatch_packet_read_discard) begin
            pkt_avail_d     = 1'b0;
            stream_active_d = 1'b0;
            rd_valid_d      = 1'b0;
        end

        if (i_rx_bad_frame) begin
            bad_inc    = 1'b1;
            wr_ptr_d   = '0;
            oversize_d = 1'b0;
        end else if (i_rx_good_frame) begin
            if (!ovs_eff && (ptr_eff != '0) && (!pkt_avail_q || i_dispatch_packet_read_discard)) begin
                wr_sel_d        = ~wr_sel_q;
                counter_d       = ptr_eff[ADDR_WIDTH-1:0] - ADDR_ONE;
                dv_d            = mask_eff;
                pkt_avail_d     = 1'b1;
                stream_done_d   = 1'b0;
                stream_active_d = 1'b0;
                rd_valid_d      = 1'b0;
                good_inc        = 1'b1;
            end else begin
                drop_inc = 1'b1;
            end
            wr_ptr_d   = '0;
            oversize_d = 1'b0;
        end

        good_cnt_d = cnt_clear ? '0 : good_cnt_q;
        bad_cnt_d  = cnt_clear ? '0 : bad_cnt_q;
        drop_cnt_d = cnt_clear ? '0 : drop_cnt_q;
        if (good_inc) good_cnt_d = good_cnt_d + 32'd1;
        if (bad_inc)  bad_cnt_d  = bad_cnt_d + 32'd1;
        if (drop_inc) drop_cnt_d = drop_cnt_d + 32'd1;
    end

    always_ff @(posedge i_clk) begin
        if (cap_write) buf_mem[{wr_sel_q, wr_ptr_q[ADDR_WIDTH-1:0]}] <= i_rx_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_areset_n) begin
            wr_sel_q        <= 1'b0;
            wr_ptr_q        <= '0;
            oversize_q      <= 1'b0;
            last_mask_q     <= '0;
            pkt_avail_q     <= 1'b0;
            counter_q       <= '0;
            dv_q            <= '0;
            stream_active_q <= 1'b0;
            stream_done_q   <= 1'b0;
            rd_addr_q       <= '0;
            rd_valid_q      <= 1'b0;
            rd_data_q       <= '0;
            good_cnt_q      <= '0;
            bad_cnt_q       <= '0;
            drop_cnt_q      <= '0;
        end else begin
            wr_sel_q        <= wr_sel_d;
            wr_ptr_q        <= wr_ptr_d;
            oversize_q      <= oversize_d;
            last_mask_q     <= last_mask_d;
            pkt_avail_q     <= pkt_avail_d;
            counter_q       <= counter_d;
            dv_q            <= dv_d;
            stream_active_q <= stream_active_d;
            stream_done_q   <= stream_done_d;
            rd_addr_q       <= rd_addr_d;
            rd_valid_q      <= rd_valid_d;
            good_cnt_q      <= good_cnt_d;
            bad_cnt_q       <= bad_cnt_d;
            drop_cnt_q      <= drop_cnt_d;
            if (stream_active_q) rd_data_q <= buf_mem[{~wr_sel_q, rd_addr_q}];
        end
    end

    always_comb begin
        api_rdata = '0;
        engine_cs = '0;
        if (api_sel == 2'd0) begin
            case (local_addr)
                10'h000: api_rdata = API_RW_WIDTH'(32'h6e74732d);
                10'h001: api_rdata = API_RW_WIDTH'(32'h64697370);
                10'h002: api_rdata = API_RW_WIDTH'(32'h00000001);
                10'h003: api_rdata = API_RW_WIDTH'(good_cnt_q);
                10'h004: api_rdata = API_RW_WIDTH'(bad_cnt_q);
                10'h005: api_rdata = API_RW_WIDTH'(drop_cnt_q);
                default: api_rdata = '0;
            endcase
        end
        for (int n = 0; n < ENGINES; n++) begin
            if (api_sel == 2'(n + 1)) begin
                api_rdata    = i_engine_read_data[n*API_RW_WIDTH +: API_RW_WIDTH];
                engine_cs[n] = i_api_cs;
            end
        end
    end

    assign o_api_read_data     = i_api_cs ? api_rdata : '0;
    assign o_engine_cs         = engine_cs;
    assign o_engine_we         = i_api_we;
    assign o_engine_address    = i_api_address;
    assign o_engine_write_data = i_api_write_data;

    assign o_dispatch_packet_available = pkt_avail_q;
    assign o_dispatch_counter          = counter_q;
    assign o_dispatch_data_valid       = dv_q;
    assign o_dispatch_fifo_empty       = fifo_empty;
    assign o_dispatch_fifo_rd_valid    = rd_valid_q;
    assign o_dispatch_fifo_rd_data     = rd_data_q;

endmodule

// File: tb/tb_nts_rx_dispatcher.sv
// Directed bench for nts_rx_dispatcher: frames are driven on the RX side, their words are
// queued as expected stream output and compared as the engine side streams them.
module tb_nts_rx_dispatcher;

    logic        i_clk = 1'b0;
    logic        i_areset_n;
    logic [7:0]  i_rx_data_valid;
    logic [63:0] i_rx_data;
    logic        i_rx_bad_frame, i_rx_good_frame;
    logic        o_dispatch_packet_available;
    logic        i_dispatch_packet_read_discard;
    logic [6:0]  o_dispatch_counter;
    logic [7:0]  o_dispatch_data_valid;
    logic        o_dispatch_fifo_empty;
    logic        i_dispatch_fifo_rd_start;
    logic        o_dispatch_fifo_rd_valid;
    logic [63:0] o_dispatch_fifo_rd_data;
    logic        i_api_cs, i_api_we;
    logic [11:0] i_api_address;
    logic [31:0] i_api_write_data, o_api_read_data;
    logic [0:0]  o_engine_cs;
    logic        o_engine_we;
    logic [11:0] o_engine_address;
    logic [31:0] o_engine_write_data, i_engine_read_data;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    logic [63:0] frame_w[$];
    logic [63:0] held_w[$];
    logic [31:0] rd;

    nts_rx_dispatcher dut (
        .i_clk(i_clk), .i_areset_n(i_areset_n),
        .i_rx_data_valid(i_rx_data_valid), .i_rx_data(i_rx_data),
        .i_rx_bad_frame(i_rx_bad_frame), .i_rx_good_frame(i_rx_good_frame),
        .o_dispatch_packet_available(o_dispatch_packet_available),
        .i_dispatch_packet_read_discard(i_dispatch_packet_read_discard),
        .o_dispatch_counter(o_dispatch_counter), .o_dispatch_data_valid(o_dispatch_data_valid),
        .o_dispatch_fifo_empty(o_dispatch_fifo_empty),
        .i_dispatch_fifo_rd_start(i_dispatch_fifo_rd_start),
        .o_dispatch_fifo_rd_valid(o_dispatch_fifo_rd_valid),
        .o_dispatch_fifo_rd_data(o_dispatch_fifo_rd_data),
        .i_api_cs(i_api_cs), .i_api_we(i_api_we), .i_api_address(i_api_address),
        .i_api_write_data(i_api_write_data), .o_api_read_data(o_api_read_data),
        .o_engine_cs(o_engine_cs), .o_engine_we(o_engine_we),
        .o_engine_address(o_engine_address), .o_engine_write_data(o_engine_write_data),
        .i_engine_read_data(i_engine_read_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every streamed word must match the head of the expected queue.
    always @(negedge i_clk) begin
        if (i_areset_n === 1'b1 && o_dispatch_fifo_rd_valid === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL stream_extra: observed=%h expected=none", o_dispatch_fifo_rd_data);
            end
            if (exp_q.size() != 0) begin
                logic [63:0] e;
                e = exp_q.pop_front();
                checks++;
                assert (o_dispatch_fifo_rd_data === e) else begin
                    failures++;
                    $error("FAIL stream_word: observed=%h expected=%h", o_dispatch_fifo_rd_data, e);
                end
            end
        end
    end

    // end_kind: 0 none, 1 good, 2 bad, 3 good+bad, 4 good with last word, 5 good+discard with last word
    task automatic send_frame(input int n, input logic [7:0] last_mask, input int end_kind);
        logic [63:0] w;
        frame_w.delete();
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            frame_w.push_back(w);
            i_rx_data_valid = (i == n - 1) ? last_mask : 8'hFF;
            i_rx_data = w;
            if (i == n - 1 && end_kind >= 4) begin
                i_rx_good_frame = 1'b1;
                if (end_kind == 5) i_dispatch_packet_read_discard = 1'b1;
            end
            tick();
        end
        i_rx_data_valid = '0;
        i_rx_good_frame = 1'b0;
        i_dispatch_packet_read_discard = 1'b0;
        if (end_kind >= 1 && end_kind <= 3) begin
            i_rx_good_frame = (end_kind == 1 || end_kind == 3);
            i_rx_bad_frame = (end_kind == 2 || end_kind == 3);
            tick();
            i_rx_good_frame = 1'b0;
            i_rx_bad_frame = 1'b0;
        end
    endtask

    task automatic stream_check(input int cnt);
        foreach (held_w[i]) exp_q.push_back(held_w[i]);
        i_dispatch_fifo_rd_start = 1'b1;
        tick();
        i_dispatch_fifo_rd_start = 1'b0;
        check("rd_valid_latency", o_dispatch_fifo_rd_valid, 0);
        tick();
        for (int i = 0; i <= cnt; i++) begin
            check("rd_valid_run", o_dispatch_fifo_rd_valid, 1);
            if (i == cnt) check("fifo_empty_last", o_dispatch_fifo_empty, 1);
            else if (i == 0) check("fifo_empty_first", o_dispatch_fifo_empty, 0);
            tick();
        end
        check("rd_valid_end", o_dispatch_fifo_rd_valid, 0);
        check("stream_all_consumed", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic discard();
        i_dispatch_packet_read_discard = 1'b1;
        tick();
        i_dispatch_packet_read_discard = 1'b0;
    endtask

    task automatic api_read(input logic [11:0] a, output logic [31:0] d);
        i_api_cs = 1'b1;
        i_api_we = 1'b0;
        i_api_address = a;
        #1;
        d = o_api_read_data;
        i_api_cs = 1'b0;
    endtask

    task automatic api_write(input logic [11:0] a, input logic [31:0] d);
        i_api_cs = 1'b1;
        i_api_we = 1'b1;
        i_api_address = a;
        i_api_write_data = d;
        tick();
        i_api_cs = 1'b0;
        i_api_we = 1'b0;
    endtask

    task automatic check_cnts(input string tag, input int g, input int b, input int dr);
        api_read(12'h003, rd); check({tag, "_good"}, rd, g);
        api_read(12'h004, rd); check({tag, "_bad"}, rd, b);
        api_read(12'h005, rd); check({tag, "_drop"}, rd, dr);
    endtask

    initial begin
        i_areset_n = 1'b0;
        i_rx_data_valid = '0; i_rx_data = '0;
        i_rx_bad_frame = 1'b0; i_rx_good_frame = 1'b0;
        i_dispatch_packet_read_discard = 1'b0; i_dispatch_fifo_rd_start = 1'b0;
        i_api_cs = 1'b0; i_api_we = 1'b0; i_api_address = '0;
        i_api_write_data = '0; i_engine_read_data = '0;
        repeat (3) tick();
        i_areset_n = 1'b1;
        check("rst_avail", o_dispatch_packet_available, 0);
        check("rst_fifo_empty", o_dispatch_fifo_empty, 1);
        check("rst_rd_valid", o_dispatch_fifo_rd_valid, 0);
        check("rst_counter", o_dispatch_counter, 0);
        check("rst_data_valid", o_dispatch_data_valid, 0);
        check("rst_rd_data", o_dispatch_fifo_rd_data, 0);
        check("rst_api_rdata", o_api_read_data, 0);
        check("rst_engine_cs", o_engine_cs, 0);
        tick();

        // 12-word frame accepted and streamed
        send_frame(12, 8'h3F, 1);
        check("a_avail", o_dispatch_packet_available, 1);
        check("a_counter", o_dispatch_counter, 11);
        check("a_data_valid", o_dispatch_data_valid, 8'h3F);
        check("a_fifo_empty", o_dispatch_fifo_empty, 0);
        held_w = frame_w;
        stream_check(11);
        check_cnts("a", 1, 0, 0);
        discard();
        check("a_disc_avail", o_dispatch_packet_available, 0);
        check("a_disc_empty", o_dispatch_fifo_empty, 1);

        // bad frame, then good+bad together
        send_frame(6, 8'hFF, 2);
        check("b_avail", o_dispatch_packet_available, 0);
        send_frame(4, 8'hFF, 3);
        check("gb_avail", o_dispatch_packet_available, 0);
        check_cnts("gb", 1, 2, 0);

        // second good frame while one is held is dropped; held buffer must survive
        send_frame(5, 8'h0F, 1);
        check("c_avail", o_dispatch_packet_available, 1);
        check("c_counter", o_dispatch_counter, 4);
        held_w = frame_w;
        send_frame(7, 8'h01, 1);
        check("d_counter_kept", o_dispatch_counter, 4);
        check("d_dv_kept", o_dispatch_data_valid, 8'h0F);
        check_cnts("d", 2, 2, 1);
        stream_check(4);

        // last word, good_frame and discard all in one cycle: frame accepted
        send_frame(9, 8'h7F, 5);
        check("e_avail", o_dispatch_packet_available, 1);
        check("e_counter", o_dispatch_counter, 8);
        check("e_data_valid", o_dispatch_data_valid, 8'h7F);
        check("e_fifo_empty", o_dispatch_fifo_empty, 0);
        held_w = frame_w;
        stream_check(8);
        check_cnts("e", 3, 2, 1);
        discard();

        api_write(12'h006, 32'h12345678);
        check_cnts("clr", 0, 0, 0);

        // oversize then exactly-full frame
        send_frame(129, 8'hFF, 1);
        check("ovs_avail", o_dispatch_packet_available, 0);
        check_cnts("ovs", 0, 0, 1);
        send_frame(128, 8'h80, 1);
        check("full_avail", o_dispatch_packet_available, 1);
        check("full_counter", o_dispatch_counter, 127);
        check("full_data_valid", o_dispatch_data_valid, 8'h80);
        held_w = frame_w;
        stream_check(127);
        i_dispatch_fifo_rd_start = 1'b1;
        tick();
        i_dispatch_fifo_rd_start = 1'b0;
        tick();
        check("restart_ignored", o_dispatch_fifo_rd_valid, 0);
        check("restart_empty", o_dispatch_fifo_empty, 1);
        check("restart_avail", o_dispatch_packet_available, 1);
        discard();

        // discard in the middle of a stream
        send_frame(10, 8'hFF, 1);
        held_w = frame_w;
        foreach (held_w[i]) exp_q.push_back(held_w[i]);
        i_dispatch_fifo_rd_start = 1'b1;
        tick();
        i_dispatch_fifo_rd_start = 1'b0;
        repeat (3) tick();
        i_dispatch_packet_read_discard = 1'b1;
        tick();
        i_dispatch_packet_read_discard = 1'b0;
        check("mid_rd_valid", o_dispatch_fifo_rd_valid, 0);
        check("mid_fifo_empty", o_dispatch_fifo_empty, 1);
        check("mid_avail", o_dispatch_packet_available, 0);
        check("mid_words_seen", exp_q.size(), 7);
        exp_q.delete();
        i_dispatch_fifo_rd_start = 1'b1;
        tick();
        i_dispatch_fifo_rd_start = 1'b0;
        tick();
        check("mid_restart_ignored", o_dispatch_fifo_rd_valid, 0);

        // API decode
        api_read(12'h000, rd); check("name0", rd, 32'h6e74732d);
        api_read(12'h001, rd); check("name1", rd, 32'h64697370);
        api_read(12'h002, rd); check("version", rd, 32'h00000001);
        api_read(12'h007, rd); check("local_other", rd, 0);
        i_engine_read_data = 32'hDEADBEEF;
        i_api_cs = 1'b1; i_api_we = 1'b0; i_api_address = 12'h405;
        #1;
        check("eng_rdata", o_api_read_data, 32'hDEADBEEF);
        check("eng_cs", o_engine_cs, 1);
        check("eng_addr", o_engine_address, 12'h405);
        i_api_we = 1'b1; i_api_write_data = 32'hCAFEF00D;
        #1;
        check("eng_we", o_engine_we, 1);
        check("eng_wdata", o_engine_write_data, 32'hCAFEF00D);
        i_api_we = 1'b0; i_api_address = 12'h805;
        #1;
        check("sel2_rdata", o_api_read_data, 0);
        check("sel2_cs", o_engine_cs, 0);
        i_api_cs = 1'b0;
        tick();

        // reset in the middle of a frame abandons it
        send_frame(3, 8'hFF, 0);
        i_areset_n = 1'b0;
        tick();
        i_areset_n = 1'b1;
        i_rx_good_frame = 1'b1;
        tick();
        i_rx_good_frame = 1'b0;
        check("rstmid_avail", o_dispatch_packet_available, 0);
        check_cnts("rstmid", 0, 0, 1);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
